// File: rtl/hdl_access_if.sv
// Request/response bundle for the HDL access responder.
interface hdl_access_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [2:0] req_target;
    logic [2:0] req_lsb;
    logic [3:0] req_width;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;

    modport master (
        output req_valid, req_op, req_target, req_lsb,
        output req_width, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_target, req_lsb,
        input  req_width, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/hdl_access_responder.sv
// Read/deposit/force/release responder over a counting reg8 and 4-entry memory.
// Force/release storage is built only when HDL_ACCESS_FORCE_EN is defined.
module hdl_access_responder #(
    parameter logic [7:0] STEP      = 8'h01,
    parameter int         MEM_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    hdl_access_if.slave bus,
    output logic [7:0] reg8_o,
    output logic [7:0] mem2_o
);
    // slot 0 is reg8, slots 1..MEM_DEPTH are mem[0..]
    localparam int NT = MEM_DEPTH + 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    typedef enum logic [1:0] {OP_RD, OP_DEP, OP_FRC, OP_REL} op_t;

    state_t     r_state, w_next;
    op_t        r_op;
    logic [2:0] r_tgt;
    logic [2:0] r_lsb;
    logic [3:0] r_width;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata;
    logic       r_err;

    logic [7:0] r_u     [NT];
    logic [7:0] w_u_nxt [NT];
    logic [7:0] w_vis   [NT];

    logic [4:0] w_sum;
    logic [8:0] w_wm9;
    logic [7:0] w_wm;
    logic [7:0] w_sel;
    logic [7:0] w_wsh;
    logic [7:0] w_tv;
    logic       w_ok;
    logic       w_do;

    assign w_sum = {2'b00, r_lsb} + {1'b0, r_width};
    assign w_wm9 = (9'd1 << r_width) - 9'd1;
    assign w_wm  = w_wm9[7:0];
    assign w_sel = w_wm << r_lsb;
    assign w_wsh = (r_wdata << r_lsb) & w_sel;

`ifdef HDL_ACCESS_FORCE_EN
    logic [7:0] r_fm     [NT];
    logic [7:0] r_fv     [NT];
    logic [7:0] w_fm_nxt [NT];
    logic [7:0] w_fv_nxt [NT];

    assign w_ok = (int'(r_tgt) < NT) && (r_width != 4'd0)
               && (r_width <= 4'd8) && (w_sum <= 5'd8);

    always_comb begin
        for (int i = 0; i < NT; i++) begin
            w_vis[i]    = (r_u[i] & ~r_fm[i]) | (r_fv[i] & r_fm[i]);
            w_fm_nxt[i] = r_fm[i];
            w_fv_nxt[i] = r_fv[i];
            if (w_do && r_tgt == 3'(i)) begin
                case (r_op)
                    OP_FRC: begin
                        w_fm_nxt[i] = r_fm[i] | w_sel;
                        w_fv_nxt[i] = (r_fv[i] & ~w_sel) | w_wsh;
                    end
                    OP_REL: w_fm_nxt[i] = r_fm[i] & ~w_sel;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NT; i++) begin
                r_fm[i] <= 8'h00;
                r_fv[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NT; i++) begin
                r_fm[i] <= w_fm_nxt[i];
                r_fv[i] <= w_fv_nxt[i];
            end
        end
    end
`else
    // force/release are rejected when the storage is not built
    assign w_ok = (int'(r_tgt) < NT) && (r_width != 4'd0)
               && (r_width <= 4'd8) && (w_sum <= 5'd8)
               && !r_op[1];

    always_comb begin
        for (int i = 0; i < NT; i++) begin
            w_vis[i] = r_u[i];
        end
    end
`endif

    assign w_do = (r_state == EXEC) && w_ok;

    always_comb begin
        w_tv = 8'h00;
        for (int i = 0; i < NT; i++) begin
            if (r_tgt == 3'(i)) w_tv = w_vis[i];
        end
    end

    // deposit on a target overrides its count on the same edge
    always_comb begin
        for (int i = 0; i < NT; i++) begin
            w_u_nxt[i] = r_u[i];
            if (run && (i == 0 || i == 1 || i == 3))
                w_u_nxt[i] = r_u[i] + STEP;
            if (w_do && r_op == OP_DEP && r_tgt == 3'(i))
                w_u_nxt[i] = (r_u[i] & ~w_sel) | w_wsh;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.req_valid) w_next = EXEC;
            EXEC:    w_next = RESP;
            RESP:    if (bus.rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_op    <= OP_RD;
            r_tgt   <= 3'd0;
            r_lsb   <= 3'd0;
            r_width <= 4'd0;
            r_wdata <= 8'h00;
            r_rdata <= 8'h00;
            r_err   <= 1'b0;
            for (int i = 0; i < NT; i++) r_u[i] <= 8'h00;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && bus.req_valid) begin
                r_op    <= op_t'(bus.req_op);
                r_tgt   <= bus.req_target;
                r_lsb   <= bus.req_lsb;
                r_width <= bus.req_width;
                r_wdata <= bus.req_wdata;
            end
            if (r_state == EXEC) begin
                r_err   <= !w_ok;
                r_rdata <= (w_do && r_op == OP_RD)
                         ? ((w_tv >> r_lsb) & w_wm) : 8'h00;
            end
            for (int i = 0; i < NT; i++) r_u[i] <= w_u_nxt[i];
        end
    end

    assign bus.req_ready = (r_state == IDLE);
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
    assign reg8_o        = w_vis[0];
    assign mem2_o        = w_vis[3];
endmodule

// File: tb/tb_hdl_access_responder.sv
// Directed vector bench for hdl_access_responder.
module tb_hdl_access_responder;
`ifdef HDL_ACCESS_FORCE_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [7:0] reg8_o;
    logic [7:0] mem2_o;

    hdl_access_if bus ();

    hdl_access_responder dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run),
        .bus    (bus.slave),
        .reg8_o (reg8_o),
        .mem2_o (mem2_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [2:0] tgt;
        logic [2:0] lsb;
        logic [3:0] w;
        logic [7:0] wd;
        logic [7:0] rd;
        logic       er;
        logic [7:0] r8;
        logic [7:0] m2;
    } vec_t;

    vec_t tv [20];

    int checks = 0;
    int failures = 0;
    logic [7:0] rd;
    logic       er;
    bit         ok;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] tgt,
                         input logic [2:0] lsb, input logic [3:0] w,
                         input logic [7:0] wd);
        @(negedge clk);
        bus.req_op     = op;
        bus.req_target = tgt;
        bus.req_lsb    = lsb;
        bus.req_width  = w;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit got, output logic [7:0] d,
                            output logic e);
        got = 1'b0;
        d = 8'h00;
        e = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                got = 1'b1;
                d = bus.rsp_rdata;
                e = bus.rsp_err;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL rsp_timeout: got no rsp_valid expected rsp_valid");
        end
    endtask

    task automatic finish_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
    endtask

    task automatic xact(input logic [1:0] op, input logic [2:0] tgt,
                        input logic [2:0] lsb, input logic [3:0] w,
                        input logic [7:0] wd, output logic [7:0] d,
                        output logic e);
        bit g;
        issue(op, tgt, lsb, w, wd);
        wait_rsp(g, d, e);
        finish_rsp();
    endtask

    initial begin
        tv[0]  = '{0, 0, 0, 8, 8'h00, 8'h00, 0, 8'h00, 8'h00};
        tv[1]  = '{1, 3, 4, 4, 8'h0A, 8'h00, 0, 8'h00, 8'hA0};
        tv[2]  = '{0, 3, 4, 4, 8'h00, 8'h0A, 0, 8'h00, 8'hA0};
        tv[3]  = '{0, 3, 0, 8, 8'h00, 8'hA0, 0, 8'h00, 8'hA0};
        tv[4]  = '{1, 0, 0, 8, 8'h3C, 8'h00, 0, 8'h3C, 8'hA0};
        tv[5]  = '{0, 0, 2, 3, 8'h00, 8'h07, 0, 8'h3C, 8'hA0};
        tv[6]  = '{1, 0, 7, 1, 8'h01, 8'h00, 0, 8'hBC, 8'hA0};
        tv[7]  = '{0, 6, 0, 8, 8'h00, 8'h00, 1, 8'hBC, 8'hA0};
        tv[8]  = '{0, 0, 6, 4, 8'h00, 8'h00, 1, 8'hBC, 8'hA0};
        tv[9]  = '{0, 0, 0, 0, 8'h00, 8'h00, 1, 8'hBC, 8'hA0};
        tv[10] = '{0, 0, 0, 9, 8'h00, 8'h00, 1, 8'hBC, 8'hA0};
        tv[11] = '{1, 7, 0, 8, 8'hFF, 8'h00, 1, 8'hBC, 8'hA0};
        tv[12] = '{1, 3, 5, 4, 8'h0F, 8'h00, 1, 8'hBC, 8'hA0};
        tv[13] = '{1, 2, 0, 8, 8'h77, 8'h00, 0, 8'hBC, 8'hA0};
        tv[14] = '{0, 2, 0, 8, 8'h00, 8'h77, 0, 8'hBC, 8'hA0};
        tv[15] = '{0, 1, 0, 8, 8'h00, 8'h00, 0, 8'hBC, 8'hA0};
        tv[16] = '{2, 0, 0, 4, 8'h05, 8'h00, !FE,
                   FE ? 8'hB5 : 8'hBC, 8'hA0};
        tv[17] = '{1, 0, 0, 8, 8'h00, 8'h00, 0,
                   FE ? 8'h05 : 8'h00, 8'hA0};
        tv[18] = '{3, 0, 0, 8, 8'h00, 8'h00, !FE, 8'h00, 8'hA0};
        tv[19] = '{0, 0, 0, 8, 8'h00, 8'h00, 0, 8'h00, 8'hA0};

        bus.req_valid  = 1'b0;
        bus.req_op     = 2'd0;
        bus.req_target = 3'd0;
        bus.req_lsb    = 3'd0;
        bus.req_width  = 4'd0;
        bus.req_wdata  = 8'h00;
        bus.rsp_ready  = 1'b0;

        do_reset();
        chk("rst_req_ready", {7'd0, bus.req_ready}, 8'h01);
        chk("rst_rsp_valid", {7'd0, bus.rsp_valid}, 8'h00);
        chk("rst_rsp_rdata", bus.rsp_rdata, 8'h00);
        chk("rst_rsp_err", {7'd0, bus.rsp_err}, 8'h00);
        chk("rst_reg8", reg8_o, 8'h00);
        chk("rst_mem2", mem2_o, 8'h00);

        // five counting edges, then read reg8
        @(negedge clk);
        run = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        run = 1'b0;
        chk("cnt5_reg8", reg8_o, 8'h05);
        xact(2'd0, 3'd0, 3'd0, 4'd8, 8'h00, rd, er);
        chk("cnt5_rdata", rd, 8'h05);
        chk("cnt5_err", {7'd0, er}, 8'h00);

        do_reset();
        for (int i = 0; i < 20; i++) begin
            xact(tv[i].op, tv[i].tgt, tv[i].lsb, tv[i].w,
                 tv[i].wd, rd, er);
            chk($sformatf("v%0d_rdata", i), rd, tv[i].rd);
            chk($sformatf("v%0d_err", i), {7'd0, er}, {7'd0, tv[i].er});
            chk($sformatf("v%0d_reg8", i), reg8_o, tv[i].r8);
            chk($sformatf("v%0d_mem2", i), mem2_o, tv[i].m2);
        end

        // deposit while counting: no double increment
        run = 1'b1;
        issue(2'd1, 3'd0, 3'd0, 4'd8, 8'h10);
        wait_rsp(ok, rd, er);
        chk("dep_run_exec", reg8_o, 8'h10);
        @(posedge clk);
        #1;
        chk("dep_run_next", reg8_o, 8'h11);
        chk("rsp_hold_valid", {7'd0, bus.rsp_valid}, 8'h01);
        chk("rsp_hold_err", {7'd0, bus.rsp_err}, 8'h00);
        run = 1'b0;
        finish_rsp();
        chk("dep_run_idle", reg8_o, 8'h11);

        if (FE) begin
            xact(2'd2, 3'd0, 3'd0, 4'd8, 8'h55, rd, er);
            chk("frc_err", {7'd0, er}, 8'h00);
            chk("frc_reg8", reg8_o, 8'h55);
            xact(2'd1, 3'd0, 3'd0, 4'd8, 8'h20, rd, er);
            chk("frc_dep_reg8", reg8_o, 8'h55);
            @(negedge clk);
            run = 1'b1;
            repeat (10) @(posedge clk);
            @(negedge clk);
            run = 1'b0;
            chk("frc_run_reg8", reg8_o, 8'h55);
            xact(2'd3, 3'd0, 3'd0, 4'd8, 8'h00, rd, er);
            chk("rel_err", {7'd0, er}, 8'h00);
            chk("rel_reg8", reg8_o, 8'h2A);
        end else begin
            xact(2'd2, 3'd0, 3'd0, 4'd8, 8'h55, rd, er);
            chk("nofrc_err", {7'd0, er}, 8'h01);
            chk("nofrc_rdata", rd, 8'h00);
            chk("nofrc_reg8", reg8_o, 8'h11);
        end

        // reset while a response is pending
        xact(2'd1, 3'd3, 3'd0, 4'd8, 8'h5A, rd, er);
        chk("pre_rst_mem2", mem2_o, 8'h5A);
        issue(2'd0, 3'd3, 3'd0, 4'd8, 8'h00);
        wait_rsp(ok, rd, er);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {7'd0, bus.rsp_valid}, 8'h00);
        chk("mid_rst_reg8", reg8_o, 8'h00);
        chk("mid_rst_mem2", mem2_o, 8'h00);
        chk("mid_rst_rdata", bus.rsp_rdata, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_valid", {7'd0, bus.rsp_valid}, 8'h00);
        chk("post_rst_ready", {7'd0, bus.req_ready}, 8'h01);
        xact(2'd1, 3'd3, 3'd0, 4'd4, 8'h06, rd, er);
        xact(2'd0, 3'd3, 3'd0, 4'd8, 8'h00, rd, er);
        chk("post_rst_rdata", rd, 8'h06);
        chk("post_rst_err", {7'd0, er}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hdl_access_responder.md
HDL_ACCESS_RESPONDER -- requirements
Module: hdl_access_responder

Interface
REQ-001 SHALL have parameter STEP, default 8'h01: increment added per counting cycle.
REQ-002 SHALL have parameter MEM_DEPTH, default 4: memory entries, fixed at 4 for this release.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port run, input, 1: enables counting of reg8, mem[0] and mem[2].
REQ-006 SHALL have port req_valid, input, 1: access request present.
REQ-007 SHALL have port req_ready, output, 1: responder can accept a request.
REQ-008 SHALL have port req_op, input, 2: 0 read, 1 deposit, 2 force, 3 release.
REQ-009 SHALL have port req_target, input, 3: 0 reg8; 1..4 mem[0..3]; 5..7 invalid.
REQ-010 SHALL have port req_lsb, input, 3: part-select low bit.
REQ-011 SHALL have port req_width, input, 4: part-select width, 1..8.
REQ-012 SHALL have port req_wdata, input, 8: right-aligned deposit/force data.
REQ-013 SHALL have port rsp_valid, output, 1: response present.
REQ-014 SHALL have port rsp_ready, input, 1: consumer accepts response.
REQ-015 SHALL have port rsp_rdata, output, 8: right-aligned read data, upper bits zero.
REQ-016 SHALL have port rsp_err, output, 1: request rejected, no state changed.
REQ-017 SHALL have ports reg8_o and mem2_o, outputs, 8 each: visible (force-applied) reg8 and mem[2].

Function
REQ-018 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; req_ready=1 only in IDLE.
REQ-019 SHALL accept a request on an edge with req_valid&&req_ready, latching all req_* fields, entering EXEC.
REQ-020 SHALL perform the access on the EXEC edge and enter RESP; rsp_valid=1 in RESP only, fields held stable until rsp_valid&&rsp_ready, then IDLE (accept-to-rsp_valid latency 2 edges).
REQ-021 SHALL, when run=1, add STEP (mod 256) to underlying reg8, mem[0], mem[2] each edge; mem[1], mem[3] never count.
REQ-022 SHALL define visible value = (underlying & ~fmask) | (fval & fmask) per target.
REQ-023 SHALL, on read, return (visible >> lsb) masked to width bits as sampled before the EXEC edge update.
REQ-024 SHALL, on deposit, replace only selected underlying bits with req_wdata; that target does not increment on that edge (deposit wins); other bits keep pre-edge value.
REQ-025 SHALL, on force, set fmask bits for the selection and load fval with req_wdata there; underlying keeps counting beneath.
REQ-026 SHALL, on release, clear fmask bits for the selection; visible bits revert to underlying at once.
REQ-027 SHALL set rsp_err=1, rsp_rdata=0, no state change when target>=5, width==0, width>8, or lsb+width>8.
REQ-028 SHALL set rsp_err=0 and rsp_rdata=0 for successful deposit/force/release.

Reset
REQ-029 SHALL, on rst_n low, asynchronously force FSM IDLE, req_ready=1 once released, rsp_valid=0, rsp_rdata=0, rsp_err=0, reg8=0, all mem=0, all fmask/fval=0.
REQ-030 SHALL discard any in-flight request or pending response on reset; no response is issued for it.

Configuration
REQ-031 SHALL, with HDL_ACCESS_FORCE_EN defined, implement force/release per REQ-022, REQ-025, REQ-026.
REQ-032 SHALL, without HDL_ACCESS_FORCE_EN, omit fmask/fval storage; visible equals underlying; ops 2 and 3 return rsp_err=1 with no state change.

Verification
REQ-033 Reset, run=1 for 5 edges, read target 0 lsb 0 width 8 -> rsp_rdata=8'h05 (plus edges elapsed to EXEC), rsp_err=0, reg8_o matches.
REQ-034 run=0, deposit target 3 (mem[2]) lsb 4 width 4 wdata 4'hA over 8'h00 -> mem2_o=8'hA0; read lsb 4 width 4 -> 8'h0A.
REQ-035 run=1, deposit target 0 value 8'h10 -> reg8_o=8'h10 after EXEC edge, 8'h11 next edge (no double increment).
REQ-036 Read target 6, and read lsb 6 width 4 -> rsp_err=1, rsp_rdata=0, memories unchanged.
REQ-037 FORCE_EN: force target 0 lsb 0 width 8 8'h55, run=1 for 10 edges -> reg8_o stays 8'h55; release -> reg8_o shows underlying count; without macro same force -> rsp_err=1.
REQ-038 Assert rst_n low during RESP with rsp_ready=0 -> rsp_valid=0 immediately, all state zero, next request serviced normally.
